mem_arbiter: RTL

- Arbitrates a single-port unified memory between instruction fetch (read-only) and the load/store path (read/write) of the single-cycle RISC-V core, enabling a multi-cycle/stalling core variant.
- Accepts one transaction at a time, issues it to memory, waits a fixed read latency, and returns data or a write acknowledge to the owning requester.
- Data path has priority, with a starvation guard for fetch.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and the load/store path.
// One transaction in flight; data has priority, with a starvation guard for fetch.
module mem_arbiter #(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CntW = $clog2(MEM_LAT + 1) + 1;
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1) + 1;

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [StW-1:0]  starve_q, starve_d;
    logic            owner_q, owner_d;  // 1 = data path owns the transaction
    logic            we_q, we_d;
    logic [31:0]     if_rdata_q, if_rdata_d;
    logic [31:0]     d_rdata_q, d_rdata_d;
    logic            if_rvalid_q, if_rvalid_d;
    logic            d_rvalid_q, d_rvalid_d;

    logic            starve_full;
    logic            d_win;
    logic            f_win;

    assign starve_full = (starve_q == StW'(STARVE_MAX));
    // Requests are masked during reset so nothing is granted while state is being cleared.
    assign d_win = !rst && d_req && !(if_req && starve_full);
    assign f_win = !rst && if_req && !d_win;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        owner_d     = owner_q;
        we_d        = we_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;

        unique case (state_q)
            StIdle: begin
                if (d_win) begin
                    d_gnt     = 1'b1;
                    mem_en    = 1'b1;
                    mem_we    = d_we;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                    owner_d   = 1'b1;
                    we_d      = d_we;
                    state_d   = StWait;
                    cnt_d     = CntW'(1);
                    if (!if_req) begin
                        starve_d = '0;
                    end else if (!starve_full) begin
                        starve_d = starve_q + StW'(1);
                    end
                end else if (f_win) begin
                    if_gnt   = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = if_addr;
                    owner_d  = 1'b0;
                    we_d     = 1'b0;
                    state_d  = StWait;
                    cnt_d    = CntW'(1);
                    starve_d = '0;
                end
            end
            StWait: begin
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(MEM_LAT)) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    if (owner_q) begin
                        d_rvalid_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            starve_q    <= '0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            if_rdata_q  <= 32'h0;
            d_rdata_q   <= 32'h0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule
